// File: rtl/ula_pkg.sv
// Shared definitions for the ULA datapath: opcode encodings for the 3-bit
// operation selector.
package ula_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

endpackage : ula_pkg

// File: rtl/ula_if.sv
// Operand/opcode/result bundle between the processor control path (master)
// and the ULA (slave). Clock, clear and preset stay outside as plain ports.
interface ula_if #(
    parameter int N = 8
);

    logic             en;
    logic [N-1:0]     A_in;
    logic [N-1:0]     B_in;
    logic [2:0]       selec;
    logic [N:0]       S;
    logic [2*N-1:0]   Smulti;

    modport master (
        output en,
        output A_in,
        output B_in,
        output selec,
        input  S,
        input  Smulti
    );

    modport slave (
        input  en,
        input  A_in,
        input  B_in,
        input  selec,
        output S,
        output Smulti
    );

endinterface : ula_if

// File: rtl/ula_mult.sv
// Combinational N x N -> 2N unsigned multiplier built as an unrolled
// shift-and-add of N partial products.
module ula_mult #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] acc;

    assign a_ext = {{N{1'b0}}, a};

    // Accumulate the partial product a<<i for every set bit b[i].
    always_comb begin
        // NOTE: blocking '=' here because acc is a running combinational
        // sum; each loop iteration must see the previous iteration's value.
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                acc = acc + (a_ext << i);
            end
        end
    end

    assign p = acc;

endmodule : ula_mult

// File: rtl/ula_core.sv
// Datapath ALU (ULA): selects one of eight operations on A_in/B_in and
// registers the result. Add/sub/logic/shift land on S (N+1 bits), multiply
// lands on Smulti (2N bits); the inactive output is loaded with zero.
// Tclr clears and Tpr presets both outputs asynchronously, Tclr winning.
module ula_core
    import ula_pkg::*;
#(
    parameter int N = 8
) (
    input  logic   Tclk,
    input  logic   Tclr,
    input  logic   Tpr,
    ula_if.slave   bus
);

    logic [N:0]     s_d;
    logic [N:0]     s_q;
    logic [2*N-1:0] smulti_d;
    logic [2*N-1:0] smulti_q;
    logic [2*N-1:0] product;
    logic [N:0]     a_ext;
    logic [N:0]     b_ext;

    assign a_ext = {1'b0, bus.A_in};
    assign b_ext = {1'b0, bus.B_in};

    ula_mult #(
        .N (N)
    ) u_mult (
        .a (bus.A_in),
        .b (bus.B_in),
        .p (product)
    );

    // Next-state: hold when disabled, otherwise compute the selected result.
    always_comb begin
        // NOTE: every output of this block is given a value before the
        // branches so no path leaves it unassigned, which would infer a latch.
        s_d      = s_q;
        smulti_d = smulti_q;
        if (bus.en) begin
            s_d      = '0;
            smulti_d = '0;
            case (bus.selec)
                OP_ADD:  s_d = a_ext + b_ext;
                OP_SUB:  s_d = a_ext - b_ext;
                OP_AND:  s_d = {1'b0, bus.A_in & bus.B_in};
                OP_OR:   s_d = {1'b0, bus.A_in | bus.B_in};
                OP_XOR:  s_d = {1'b0, bus.A_in ^ bus.B_in};
                OP_NOT:  s_d = {1'b0, ~bus.A_in};
                OP_SHL:  s_d = {bus.A_in, 1'b0};
                OP_MUL:  smulti_d = product;
                default: s_d = '0;
            endcase
        end
    end

    // Output registers with asynchronous clear (priority) and preset.
    always_ff @(posedge Tclk or negedge Tclr or negedge Tpr) begin
        // NOTE: non-blocking '<=' for all flop updates so every register
        // samples pre-edge values regardless of statement order.
        if (!Tclr) begin
            s_q      <= '0;
            smulti_q <= '0;
        end else if (!Tpr) begin
            s_q      <= '1;
            smulti_q <= '1;
        end else begin
            s_q      <= s_d;
            smulti_q <= smulti_d;
        end
    end

    assign bus.S      = s_q;
    assign bus.Smulti = smulti_q;

endmodule : ula_core

// File: tb/tb_ula_core.sv
// Directed bench for ula_core: reset/preset behaviour, one-cycle latency,
// every opcode with hand-computed results, boundaries and enable hold.
module tb_ula_core;
    import ula_pkg::*;

    localparam int N = 8;

    logic Tclk = 1'b0;
    logic Tclr;
    logic Tpr;

    int n_cmp = 0;
    int n_err = 0;

    logic [N:0]     prev_s;
    logic [2*N-1:0] prev_m;

    ula_if #(.N(N)) bus ();

    ula_core #(.N(N)) dut (
        .Tclk (Tclk),
        .Tclr (Tclr),
        .Tpr  (Tpr),
        .bus  (bus)
    );

    always #5 Tclk = ~Tclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one operation at a negedge, confirm outputs unchanged before the
    // edge, then confirm the registered result just after the edge.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [8:0] es, input logic [15:0] em);
        @(negedge Tclk);
        bus.en    = 1'b1;
        bus.selec = sel;
        bus.A_in  = a;
        bus.B_in  = b;
        #1;
        check({tag, "_pre_S"}, 32'(bus.S), 32'(prev_s));
        check({tag, "_pre_M"}, 32'(bus.Smulti), 32'(prev_m));
        @(posedge Tclk);
        #1;
        check({tag, "_S"}, 32'(bus.S), 32'(es));
        check({tag, "_M"}, 32'(bus.Smulti), 32'(em));
        prev_s = es;
        prev_m = em;
    endtask

    initial begin
        // Reset held from time 0 with enable and valid operands present.
        Tclr      = 1'b0;
        Tpr       = 1'b1;
        bus.en    = 1'b1;
        bus.selec = OP_ADD;
        bus.A_in  = 8'd55;
        bus.B_in  = 8'd100;
        #3;
        check("rst_async_S", 32'(bus.S), 32'h0);
        check("rst_async_M", 32'(bus.Smulti), 32'h0);
        #4;
        check("rst_edge_S", 32'(bus.S), 32'h0);
        check("rst_edge_M", 32'(bus.Smulti), 32'h0);
        @(negedge Tclk);
        Tclr = 1'b1;
        @(posedge Tclk);
        #1;
        check("rel_load_S", 32'(bus.S), 32'd155);
        check("rel_load_M", 32'(bus.Smulti), 32'h0);
        prev_s = 9'd155;
        prev_m = 16'h0;

        // Multiply
        run_op("mul_55_100", OP_MUL, 8'd55,  8'd100, 9'h0, 16'h157C);
        run_op("mul_200_3",  OP_MUL, 8'd200, 8'd3,   9'h0, 16'd600);
        run_op("mul_50_50",  OP_MUL, 8'd50,  8'd50,  9'h0, 16'd2500);
        run_op("mul_ff_ff",  OP_MUL, 8'hFF,  8'hFF,  9'h0, 16'hFE01);
        run_op("mul_0_7",    OP_MUL, 8'd0,   8'd7,   9'h0, 16'h0);

        // Add
        run_op("add_55_100", OP_ADD, 8'd55,  8'd100, 9'd155, 16'h0);
        run_op("add_200_3",  OP_ADD, 8'd200, 8'd3,   9'd203, 16'h0);
        run_op("add_50_50",  OP_ADD, 8'd50,  8'd50,  9'd100, 16'h0);
        run_op("add_ff_ff",  OP_ADD, 8'hFF,  8'hFF,  9'h1FE, 16'h0);

        // Subtract
        run_op("sub_55_100", OP_SUB, 8'd55,  8'd100, 9'h1D3, 16'h0);
        run_op("sub_200_3",  OP_SUB, 8'd200, 8'd3,   9'd197, 16'h0);
        run_op("sub_50_50",  OP_SUB, 8'd50,  8'd50,  9'h0,   16'h0);
        run_op("sub_0_0",    OP_SUB, 8'd0,   8'd0,   9'h0,   16'h0);

        // Logic and shift
        run_op("and", OP_AND, 8'hA5, 8'h0F, 9'h005, 16'h0);
        run_op("or",  OP_OR,  8'hA5, 8'h0F, 9'h0AF, 16'h0);
        run_op("xor", OP_XOR, 8'hA5, 8'h0F, 9'h0AA, 16'h0);
        run_op("not", OP_NOT, 8'hA5, 8'h0F, 9'h05A, 16'h0);
        run_op("shl", OP_SHL, 8'hA5, 8'h0F, 9'h14A, 16'h0);

        // Enable low holds S while inputs change
        run_op("hold_pre_add", OP_ADD, 8'd55, 8'd100, 9'd155, 16'h0);
        @(negedge Tclk);
        bus.en    = 1'b0;
        bus.selec = OP_MUL;
        bus.A_in  = 8'hFF;
        bus.B_in  = 8'hFF;
        repeat (2) @(posedge Tclk);
        #1;
        check("hold_S", 32'(bus.S), 32'd155);
        check("hold_S_M", 32'(bus.Smulti), 32'h0);

        // Enable low holds Smulti while inputs change
        run_op("hold_pre_mul", OP_MUL, 8'd200, 8'd3, 9'h0, 16'd600);
        @(negedge Tclk);
        bus.en    = 1'b0;
        bus.selec = OP_ADD;
        bus.A_in  = 8'd1;
        bus.B_in  = 8'd2;
        repeat (2) @(posedge Tclk);
        #1;
        check("hold_M_S", 32'(bus.S), 32'h0);
        check("hold_M", 32'(bus.Smulti), 32'd600);

        // Preset mid-cycle, immediate and dominant over a running clock
        @(negedge Tclk);
        bus.en = 1'b1;
        #2;
        Tpr = 1'b0;
        #1;
        check("pr_async_S", 32'(bus.S), 32'h1FF);
        check("pr_async_M", 32'(bus.Smulti), 32'hFFFF);
        @(posedge Tclk);
        #1;
        check("pr_edge_S", 32'(bus.S), 32'h1FF);
        check("pr_edge_M", 32'(bus.Smulti), 32'hFFFF);

        // Clear together with preset: clear wins
        Tclr = 1'b0;
        #1;
        check("clr_pr_S", 32'(bus.S), 32'h0);
        check("clr_pr_M", 32'(bus.Smulti), 32'h0);
        @(negedge Tclk);
        bus.en = 1'b0;
        Tpr    = 1'b1;
        Tclr   = 1'b1;
        prev_s = 9'h0;
        prev_m = 16'h0;

        // Normal operation after release, then a mid-stream clear
        run_op("post_rel_mul", OP_MUL, 8'd50, 8'd50, 9'h0, 16'd2500);
        @(negedge Tclk);
        #2;
        Tclr = 1'b0;
        #1;
        check("mid_clr_S", 32'(bus.S), 32'h0);
        check("mid_clr_M", 32'(bus.Smulti), 32'h0);
        @(negedge Tclk);
        bus.en = 1'b0;
        Tclr   = 1'b1;
        prev_s = 9'h0;
        prev_m = 16'h0;
        run_op("post_clr_add", OP_ADD, 8'd200, 8'd3, 9'd203, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ula_core
